// File: rtl/down_counter.sv
// Loadable down-counter: counts a loaded value N down to zero on enabled cycles
// and emits a one-cycle done pulse; with RELOAD=1 it restarts from N for periodic ticks.
module down_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             terminal;
  logic             can_decrement;

  assign terminal      = (count_q == CNT_ONE);
  assign can_decrement = (count_q > CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      // A load always wins, even over a coincident terminal count.
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != CNT_ZERO) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (enable) begin
            if (terminal) begin
              done_d = 1'b1;
              if (RELOAD) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = IDLE;
              end
            end else if (can_decrement) begin
              count_d = count_q - CNT_ONE;
            end else begin
              // Zero while running is unreachable; park safely without wrapping.
              count_d = CNT_ZERO;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign zero  = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: a one-shot and a periodic instance share the
// same stimulus; each scenario checks the instance it targets.
module tb_down_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;

  logic [W-1:0] os_count, pr_count;
  logic         os_busy, os_done, os_zero;
  logic         pr_busy, pr_done, pr_zero;

  int n_cmp;
  int n_err;

  down_counter #(.WIDTH(W), .RELOAD(1'b0)) u_oneshot (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .enable(enable),
    .count(os_count), .busy(os_busy), .done(os_done), .zero(os_zero)
  );

  down_counter #(.WIDTH(W), .RELOAD(1'b1)) u_periodic (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .enable(enable),
    .count(pr_count), .busy(pr_busy), .done(pr_done), .zero(pr_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    enable = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic en);
    load = 1'b1;
    load_value = v;
    enable = en;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] en_seq;
    logic [W-1:0] exp_c;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    load = 1'b1;
    load_value = 8'd9;
    enable = 1'b1;

    // 1. Reset held with load asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_count", os_count, 0);
      check("rst_busy", os_busy, 0);
      check("rst_done", os_done, 0);
      check("rst_zero", os_zero, 1);
    end
    rst = 1'b0;
    load = 1'b0;

    // 2. One-shot N=5
    do_load(8'd5, 1'b1);
    check("os5_load_count", os_count, 5);
    check("os5_load_busy", os_busy, 1);
    for (int i = 4; i >= 1; i--) begin
      tick();
      check("os5_count", os_count, i);
      check("os5_done_low", os_done, 0);
    end
    tick();
    check("os5_term_count", os_count, 0);
    check("os5_term_done", os_done, 1);
    check("os5_term_busy", os_busy, 0);
    check("os5_term_zero", os_zero, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("os5_hold_count", os_count, 0);
      check("os5_hold_done", os_done, 0);
    end

    // 3. Enable gating N=3, enable 1,0,0,1,1 -> 2,2,2,1,0
    do_reset();
    do_load(8'd3, 1'b0);
    check("gate_load", os_count, 3);
    enable = 1'b1; tick(); check("gate_c1", os_count, 2); check("gate_d1", os_done, 0);
    enable = 1'b0; tick(); check("gate_c2", os_count, 2); check("gate_d2", os_done, 0);
    enable = 1'b0; tick(); check("gate_c3", os_count, 2); check("gate_d3", os_done, 0);
    enable = 1'b1; tick(); check("gate_c4", os_count, 1); check("gate_d4", os_done, 0);
    enable = 1'b1; tick(); check("gate_c5", os_count, 0); check("gate_d5", os_done, 1);

    // 4. Periodic N=4, 20 enabled cycles
    do_reset();
    do_load(8'd4, 1'b1);
    check("per_load", pr_count, 4);
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_c = 8'(4 - (i % 4));
      check("per_count", pr_count, exp_c);
      check("per_done", pr_done, (i % 4 == 0) ? 1 : 0);
      check("per_busy", pr_busy, 1);
    end

    // Periodic N=1: done high every cycle
    do_load(8'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("per1_done", pr_done, 1);
      check("per1_count", pr_count, 1);
    end

    // 5a. Load 0
    do_reset();
    do_load(8'd0, 1'b1);
    check("ld0_busy", os_busy, 0);
    check("ld0_done", os_done, 0);
    check("ld0_zero", os_zero, 1);
    check("ld0_pbusy", pr_busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld0_hold_done", os_done, 0);
      check("ld0_hold_count", os_count, 0);
    end

    // 5b. Load 255
    do_reset();
    do_load(8'd255, 1'b1);
    for (int i = 0; i < 254; i++) begin
      tick();
      if (os_done !== 1'b0) check("ld255_early_done", os_done, 0);
    end
    check("ld255_pre_count", os_count, 1);
    check("ld255_pre_done", os_done, 0);
    tick();
    check("ld255_done", os_done, 1);
    check("ld255_count", os_count, 0);

    // 5c. Load 7 coincident with terminal count
    do_reset();
    do_load(8'd2, 1'b1);
    tick();
    check("ldterm_pre", os_count, 1);
    do_load(8'd7, 1'b1);
    check("ldterm_count", os_count, 7);
    check("ldterm_done", os_done, 0);
    check("ldterm_busy", os_busy, 1);
    check("ldterm_pdone", pr_done, 0);

    // 6. Async reset mid-count
    do_reset();
    do_load(8'd10, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("arst_pre", os_count, 6);
    #2 rst = 1'b1;
    #1;
    check("arst_count", os_count, 0);
    check("arst_busy", os_busy, 0);
    check("arst_done", os_done, 0);
    check("arst_pcount", pr_count, 0);
    tick();
    rst = 1'b0;
    enable = 1'b1;
    en_seq = 4'hF;
    for (int i = 0; i < 4; i++) begin
      enable = en_seq[i];
      tick();
      check("arst_idle_count", os_count, 0);
      check("arst_idle_busy", os_busy, 0);
      check("arst_idle_done", os_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
